stack_game_ctrl: RTL and testbench



---
 rtl/stack_game_ctrl_if.sv | 28 ++
 rtl/stack_game_ctrl.sv | 162 ++++++++++++++++
 tb/tb_stack_game_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/stack_game_ctrl_if.sv
// Control/display bundle between the stacking-game sequencer and its environment.
// The master drives the game inputs, and the slave (the sequencer) drives the draw-side state.
interface stack_game_ctrl_if;
  logic        tick;
  logic        start;
  logic        btn_left;
  logic        btn_right;
  logic [10:0] spawn_rnd;
  logic [9:0]  pos_x;
  logic [31:0] colors;
  logic [9:0]  fall_x;
  logic [9:0]  fall_y;
  logic [1:0]  fall_clr;
  logic [4:0]  height;
  logic [1:0]  misses;
  logic        game_over;
  logic        win;

  modport master (
    output tick, start, btn_left, btn_right, spawn_rnd,
    input  pos_x, colors, fall_x, fall_y, fall_clr, height, misses, game_over, win
  );

  modport slave (
    input  tick, start, btn_left, btn_right, spawn_rnd,
    output pos_x, colors, fall_x, fall_y, fall_clr, height, misses, game_over, win
  );
endinterface

// File: rtl/stack_game_ctrl.sv
// Stacking-game sequencer: platform position, 16-layer color stack and falling block.
// Game state advances on frame ticks; all outputs come straight from registers.
module stack_game_ctrl #(
  parameter int unsigned WIDTH        = 100,
  parameter int unsigned HEIGHT_RATIO = 20,
  parameter int unsigned BASE_Y       = 400,
  parameter int unsigned SCREEN_W     = 640,
  parameter int unsigned STEP         = 4,
  parameter int unsigned FALL_STEP    = 4,
  parameter int unsigned TOL          = 50,
  parameter int unsigned MAX_MISS     = 3
) (
  input  logic              dclk,
  input  logic              rst_n,
  stack_game_ctrl_if.slave  bus
);

  localparam logic [9:0]  PosMax   = 10'(SCREEN_W - WIDTH);
  localparam logic [9:0]  PosInit  = 10'((SCREEN_W - WIDTH) / 2);
  localparam logic [9:0]  Step     = 10'(STEP);
  localparam logic [10:0] BaseY    = 11'(BASE_Y);
  localparam logic [10:0] Ratio    = 11'(HEIGHT_RATIO);
  localparam logic [10:0] FallStep = 11'(FALL_STEP);
  localparam logic [10:0] Tol      = 11'(TOL);
  localparam logic [1:0]  MaxMiss  = 2'(MAX_MISS);

  typedef enum logic [2:0] {StIdle, StSpawn, StFall, StLand, StOver, StFull} state_e;

  state_e      state_q, state_d;
  logic [9:0]  pos_x_q, pos_x_d;
  logic [31:0] colors_q, colors_d;
  logic [9:0]  fall_x_q, fall_x_d;
  logic [9:0]  fall_y_q, fall_y_d;
  logic [1:0]  fall_clr_q, fall_clr_d;
  logic [4:0]  height_q, height_d;
  logic [1:0]  misses_q, misses_d;
  logic        game_over_q, game_over_d;
  logic        win_q, win_d;

  logic [9:0]  pos_step;
  logic [10:0] land_y;
  logic [10:0] fall_y_nxt;
  logic        catch_hit;

  always_comb begin
    pos_step = pos_x_q;
    // Compare before stepping so the clamp never wraps.
    if (bus.btn_left && !bus.btn_right) begin
      pos_step = (pos_x_q < Step) ? '0 : pos_x_q - Step;
    end else if (bus.btn_right && !bus.btn_left) begin
      pos_step = (pos_x_q > PosMax - Step) ? PosMax : pos_x_q + Step;
    end
  end

  assign land_y     = BaseY - Ratio * {6'd0, height_q};
  assign fall_y_nxt = {1'b0, fall_y_q} + FallStep;
  assign catch_hit  = (({1'b0, fall_x_q} + Tol) > {1'b0, pos_x_q}) &&
                      (({1'b0, pos_x_q} + Tol) > {1'b0, fall_x_q});

  always_comb begin
    state_d     = state_q;
    pos_x_d     = pos_x_q;
    colors_d    = colors_q;
    fall_x_d    = fall_x_q;
    fall_y_d    = fall_y_q;
    fall_clr_d  = fall_clr_q;
    height_d    = height_q;
    misses_d    = misses_q;
    game_over_d = game_over_q;
    win_d       = win_q;

    unique case (state_q)
      StIdle, StOver, StFull: begin
        if (bus.start) begin
          state_d     = StSpawn;
          colors_d    = '0;
          height_d    = 5'd1;
          misses_d    = '0;
          pos_x_d     = PosInit;
          game_over_d = 1'b0;
          win_d       = 1'b0;
        end
      end
      StSpawn: begin
        if (bus.tick) pos_x_d = pos_step;
        fall_x_d   = {1'b0, bus.spawn_rnd[8:0]};
        fall_y_d   = '0;
        fall_clr_d = (bus.spawn_rnd[10:9] == 2'b00) ? 2'b01 : bus.spawn_rnd[10:9];
        state_d    = StFall;
      end
      StFall: begin
        if (bus.tick) begin
          pos_x_d = pos_step;
          if (fall_y_nxt >= land_y) begin
            fall_y_d = land_y[9:0];
            state_d  = StLand;
          end else begin
            fall_y_d = fall_y_nxt[9:0];
          end
        end
      end
      StLand: begin
        if (bus.tick) pos_x_d = pos_step;
        fall_clr_d = 2'b00;
        // Catch decision uses the platform position held before this cycle's move.
        if (catch_hit) begin
          colors_d[{height_q[3:0], 1'b0} +: 2] = fall_clr_q;
          height_d = height_q + 5'd1;
        end else begin
          misses_d = misses_q + 2'd1;
        end
        if (height_d == 5'd16) begin
          state_d = StFull;
          win_d   = 1'b1;
        end else if (misses_d == MaxMiss) begin
          state_d     = StOver;
          game_over_d = 1'b1;
        end else begin
          state_d = StSpawn;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pos_x_q     <= PosInit;
      colors_q    <= '0;
      fall_x_q    <= '0;
      fall_y_q    <= '0;
      fall_clr_q  <= '0;
      height_q    <= 5'd1;
      misses_q    <= '0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_x_q     <= pos_x_d;
      colors_q    <= colors_d;
      fall_x_q    <= fall_x_d;
      fall_y_q    <= fall_y_d;
      fall_clr_q  <= fall_clr_d;
      height_q    <= height_d;
      misses_q    <= misses_d;
      game_over_q <= game_over_d;
      win_q       <= win_d;
    end
  end

  assign bus.pos_x     = pos_x_q;
  assign bus.colors    = colors_q;
  assign bus.fall_x    = fall_x_q;
  assign bus.fall_y    = fall_y_q;
  assign bus.fall_clr  = fall_clr_q;
  assign bus.height    = height_q;
  assign bus.misses    = misses_q;
  assign bus.game_over = game_over_q;
  assign bus.win       = win_q;

endmodule

// File: tb/tb_stack_game_ctrl.sv
// Directed bench for stack_game_ctrl: catch, miss, clamps, game over, win, color map and reset.
module tb_stack_game_ctrl;

  logic dclk;
  logic rst_n;
  int   checks;
  int   errors;

  stack_game_ctrl_if bus ();

  stack_game_ctrl dut (
    .dclk  (dclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge dclk);
    #1;
  endtask

  task automatic tick_n(input int n, input logic l, input logic r);
    bus.btn_left  = l;
    bus.btn_right = r;
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1;
      cycle();
    end
    bus.tick      = 1'b0;
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.tick      = 1'b0;
    bus.start     = 1'b0;
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b0;
    bus.spawn_rnd = '0;
    #12;
    check("rst_pos_x", 32'(bus.pos_x), 32'd270);
    check("rst_colors", bus.colors, 32'h0);
    check("rst_height", 32'(bus.height), 32'd1);
    check("rst_fall_clr", 32'(bus.fall_clr), 32'd0);
    check("rst_flags", {30'd0, bus.game_over, bus.win}, 32'd0);
    cycle();
    rst_n = 1'b1;
    cycle();

    // Game 1, block 1: catch at centre.
    bus.spawn_rnd = {2'b10, 9'd270};
    pulse_start();
    cycle();
    check("b1_fall_x", 32'(bus.fall_x), 32'd270);
    check("b1_fall_clr", 32'(bus.fall_clr), 32'd2);
    check("b1_fall_y0", 32'(bus.fall_y), 32'd0);
    tick_n(94, 1'b0, 1'b0);
    check("b1_fall_y94", 32'(bus.fall_y), 32'd376);
    tick_n(1, 1'b0, 1'b0);
    check("b1_land_y", 32'(bus.fall_y), 32'd380);
    bus.spawn_rnd = {2'b11, 9'd0};
    cycle();
    check("b1_colors", bus.colors, 32'h0000_0008);
    check("b1_height", 32'(bus.height), 32'd2);
    check("b1_clr_off", 32'(bus.fall_clr), 32'd0);

    // Block 2: miss at x=0.
    cycle();
    check("b2_fall_x", 32'(bus.fall_x), 32'd0);
    check("b2_fall_clr", 32'(bus.fall_clr), 32'd3);
    tick_n(90, 1'b0, 1'b0);
    check("b2_land_y", 32'(bus.fall_y), 32'd360);
    bus.spawn_rnd = {2'b00, 9'd0};
    cycle();
    check("b2_misses", 32'(bus.misses), 32'd1);
    check("b2_height", 32'(bus.height), 32'd2);
    check("b2_colors", bus.colors, 32'h0000_0008);

    // Block 3: color 00 maps to 01, left clamp, both buttons hold, then catch at x=0.
    cycle();
    check("b3_fall_clr", 32'(bus.fall_clr), 32'd1);
    tick_n(70, 1'b1, 1'b0);
    check("clamp_left", 32'(bus.pos_x), 32'd0);
    tick_n(5, 1'b1, 1'b1);
    check("both_hold", 32'(bus.pos_x), 32'd0);
    tick_n(15, 1'b0, 1'b0);
    bus.spawn_rnd = {2'b01, 9'd511};
    cycle();
    check("b3_colors", bus.colors, 32'h0000_0018);
    check("b3_height", 32'(bus.height), 32'd3);

    // Block 4: move right during fall, miss.
    cycle();
    tick_n(85, 1'b0, 1'b1);
    check("b4_pos_x", 32'(bus.pos_x), 32'd340);
    bus.spawn_rnd = {2'b10, 9'd100};
    cycle();
    check("b4_misses", 32'(bus.misses), 32'd2);

    // Block 5: right clamp, third miss ends the game.
    cycle();
    tick_n(60, 1'b0, 1'b1);
    check("clamp_right", 32'(bus.pos_x), 32'd540);
    tick_n(25, 1'b0, 1'b0);
    cycle();
    check("over_flag", 32'(bus.game_over), 32'd1);
    check("over_misses", 32'(bus.misses), 32'd3);
    check("over_win", 32'(bus.win), 32'd0);
    check("over_colors", bus.colors, 32'h0000_0018);
    tick_n(3, 1'b1, 1'b0);
    check("over_no_move", 32'(bus.pos_x), 32'd540);

    // Restart clears the game.
    bus.spawn_rnd = {2'b11, 9'd270};
    pulse_start();
    check("restart_misses", 32'(bus.misses), 32'd0);
    check("restart_height", 32'(bus.height), 32'd1);
    check("restart_colors", bus.colors, 32'h0);
    check("restart_pos", 32'(bus.pos_x), 32'd270);
    check("restart_over", 32'(bus.game_over), 32'd0);

    // Game 2: fifteen catches fill the stack.
    for (int h = 1; h <= 15; h++) begin
      cycle();
      tick_n(100 - 5 * h, 1'b0, 1'b0);
      if (h == 2) bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
      check($sformatf("fill_height_%0d", h), 32'(bus.height), 32'(h + 1));
    end
    check("full_win", 32'(bus.win), 32'd1);
    check("full_over", 32'(bus.game_over), 32'd0);
    check("full_colors", bus.colors, 32'hFFFF_FFFC);

    // Game 3: one catch, then async reset in the middle of the next fall.
    bus.spawn_rnd = {2'b10, 9'd270};
    pulse_start();
    check("g3_win_clr", 32'(bus.win), 32'd0);
    cycle();
    tick_n(95, 1'b0, 1'b0);
    bus.spawn_rnd = {2'b00, 9'd5};
    cycle();
    check("g3_colors", bus.colors, 32'h0000_0008);
    cycle();
    check("g3_fall_clr", 32'(bus.fall_clr), 32'd1);
    tick_n(10, 1'b0, 1'b1);
    check("g3_fall_y", 32'(bus.fall_y), 32'd40);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_pos", 32'(bus.pos_x), 32'd270);
    check("mid_rst_colors", bus.colors, 32'h0);
    check("mid_rst_height", 32'(bus.height), 32'd1);
    check("mid_rst_fall", {bus.fall_x, bus.fall_y, 10'd0, bus.fall_clr}, 32'h0);
    check("mid_rst_misc", {27'd0, bus.misses, bus.game_over, bus.win}, 32'd0);
    cycle();
    rst_n = 1'b1;
    tick_n(4, 1'b1, 1'b0);
    check("idle_no_move", 32'(bus.pos_x), 32'd270);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
